// File: rtl/debounce.sv
// Switch/button debouncer: two-flop synchroniser feeding a stability FSM.
// q moves only after the synchronised input holds a new level STABLE_CNT cycles.
module debounce #(
  parameter int STABLE_CNT = 16,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    LO,
    WAIT_HI,
    HI,
    WAIT_LO
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             s1, s2;
  logic             q_nx, rise_nx, fall_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      q     <= q_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
    end
  end

  // Any sample back at the current q level aborts the pending change.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    q_nx     = q;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    unique case (state)
      LO: begin
        if (s2) begin
          state_nx = WAIT_HI;
          cnt_nx   = ONE;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_nx = LO;
        end else if (cnt == LAST) begin
          state_nx = HI;
          q_nx     = 1'b1;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      HI: begin
        if (!s2) begin
          state_nx = WAIT_LO;
          cnt_nx   = ONE;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_nx = HI;
        end else if (cnt == LAST) begin
          state_nx = LO;
          q_nx     = 1'b0;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        state_nx = LO;
        q_nx     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce.sv
// Randomised and directed bench for debounce against a sliding-window
// reference: q flips once the last STABLE_CNT synchronised samples all differ.
module tb_debounce;

  localparam int S = 4;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d = 1'b0;
  logic q, rise, fall;

  debounce #(
    .STABLE_CNT(S),
    .CNT_W(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .d(d),
    .q(q),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  bit hist[$];
  bit m_q, m_rise, m_fall;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Synchroniser flops reset to 0: two zero samples precede the first d.
  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    m_q = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
  endtask

  task automatic model_edge(input bit dv);
    bit all_diff;
    int n;
    hist.push_back(dv);
    if (hist.size() > 64) void'(hist.pop_front());
    n = hist.size();
    all_diff = (n >= S + 2);
    if (all_diff)
      for (int i = 0; i < S; i++)
        if (hist[n-3-i] == m_q) all_diff = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (all_diff) begin
      m_q = ~m_q;
      if (m_q) m_rise = 1'b1;
      else m_fall = 1'b1;
    end
  endtask

  // Drive at negedge, clock once, compare #1 after the edge.
  task automatic step(input bit dv);
    d = dv;
    @(posedge clk);
    model_edge(dv);
    #1;
    check("q", q, m_q);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("excl", rise & fall, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_q", q, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_cnt", dut.cnt, 0);
    repeat (2) @(negedge clk);
    check("rst_hold_q", q, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  int idx, pulses;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Clean rise: q and rise at edge 5, rise gone at edge 6.
    for (int i = 0; i < 5; i++) step(1'b1);
    check("clean_pre_q", q, 0);
    step(1'b1);
    check("clean_q", q, 1);
    check("clean_rise", rise, 1);
    step(1'b1);
    check("clean_rise_off", rise, 0);
    repeat (3) step(1'b1);

    // Clean fall, then a 3-cycle high glitch that must be ignored.
    idx = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0);
      if (fall && idx < 0) idx = i;
    end
    check("fall_lat", idx, 5);
    check("fall_q", q, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      pulses += int'(rise) + int'(fall);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      pulses += int'(rise) + int'(fall);
    end
    check("short_hi_q", q, 0);
    check("short_hi_pulses", pulses, 0);

    // Bounce 1,1,0 then hold 1: rise exactly 5 edges after the last 0->1.
    step(1'b1);
    step(1'b1);
    step(1'b0);
    idx = -1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      if (rise) begin
        pulses++;
        if (idx < 0) idx = i;
      end
    end
    check("bounce_lat", idx, 5);
    check("bounce_pulses", pulses, 1);
    for (int i = 0; i < 10; i++) step(1'b0);

    // Toggle every cycle: nothing may move.
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(i[0]);
      pulses += int'(rise) + int'(fall) + int'(q);
    end
    check("toggle_quiet", pulses, 0);
    for (int i = 0; i < 6; i++) step(1'b0);

    // Reset 3 edges into WAIT_HI, then q after normal latency.
    for (int i = 0; i < 5; i++) step(1'b1);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1);
    check("rel_pre_q", q, 0);
    step(1'b1);
    check("rel_q", q, 1);
    check("rel_rise", rise, 1);

    // Reset while in HI must not produce a fall pulse.
    repeat (3) step(1'b1);
    d = 1'b0;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      pulses += int'(rise) + int'(fall);
    end
    check("hi_rst_pulses", pulses, 0);

    // Random runs of varying length against the window model.
    for (int r = 0; r < 400; r++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) step(lvl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
